// File: rtl/alu_pkg.sv
// Shared encodings and fixed-point constants for the cosine phase front-end.
package alu_pkg;

  localparam int PHASE_W = 32;
  localparam int FRAC_W  = 16;
  localparam int DATA_W  = 18;
  localparam int COEF_W  = 18;
  localparam int FOLD_W  = FRAC_W + 1;
  localparam int PROD_W  = FOLD_W + COEF_W;

  localparam logic [COEF_W-1:0] HALF_PI_Q16 = 18'h19220;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCALE = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SIGN  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_shift_add_mult.sv
// Unsigned sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// done is high during the final iteration; product is valid in that same cycle.
module alu_shift_add_mult import alu_pkg::*; #(
  parameter int A_W = FOLD_W,
  parameter int B_W = COEF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 done,
  output logic [A_W+B_W-1:0]   product
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(A_W + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [A_W-1:0]   mplier;
  logic [P_W-1:0]   mcand;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   acc_next;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    done     = busy && (cnt == CNT_W'(A_W - 1));
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      busy <= !done;
      cnt  <= cnt + 1'b1;
    end
  end

  // datapath: shift registers carry no reset, control gates them
  always_ff @(posedge clk) begin
    if (start) begin
      mplier <= a;
      mcand  <= P_W'(b);
      acc    <= '0;
    end else if (busy) begin
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      acc    <= acc_next;
    end
  end

endmodule

// File: rtl/alu_cos_phase_reduce.sv
// Folds a 32-bit phase into quadrant 0, scales to s1.16 radians, drives alu_calc_cos, re-signs the result.
// Optional watchdog on the cosine answer: define ALU_COS_TIMEOUT_EN.
module alu_cos_phase_reduce import alu_pkg::*; #(
  parameter logic [COEF_W-1:0] HALF_PI_Q16    = alu_pkg::HALF_PI_Q16,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PHASE_W-1:0]        phase_in,
  input  logic                      phase_valid,
  output logic                      phase_ready,
  output logic signed [DATA_W-1:0]  cos_x,
  output logic                      cos_do_calc,
  input  logic signed [DATA_W-1:0]  cos_res,
  input  logic                      cos_calc_done,
  output logic signed [DATA_W-1:0]  cos_out,
  output logic                      cos_out_valid,
  output logic                      busy,
  output logic                      timeout_err
);

  function automatic logic signed [DATA_W-1:0] negate_wrap(input logic signed [DATA_W-1:0] v);
    // -0x20000 wraps onto itself by design; no saturation
    negate_wrap = -v;
  endfunction

  state_t              state, state_next;
  logic [1:0]          quad;
  logic [FRAC_W-1:0]   frac;
  logic [FOLD_W-1:0]   f_fold;
  logic                neg_fold;
  logic                neg_p0;
  logic                accept;
  logic                mult_done;
  logic [PROD_W-1:0]   product;
  logic                timeout_hit;
  logic                unused_bits;

  assign phase_ready = (state == ST_IDLE);
  assign busy        = !phase_ready;
  assign accept      = phase_valid && phase_ready;
  assign unused_bits = ^{phase_in[PHASE_W-FRAC_W-3:0], product[PROD_W-1], product[FRAC_W-1:0]};

  always_comb begin
    quad     = phase_in[PHASE_W-1 -: 2];
    frac     = phase_in[PHASE_W-3 -: FRAC_W];
    f_fold   = quad[0] ? (FOLD_W'(1 << FRAC_W) - {1'b0, frac}) : {1'b0, frac};
    neg_fold = quad[1] ^ quad[0];
  end

  alu_shift_add_mult #(.A_W(FOLD_W), .B_W(COEF_W)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .a       (f_fold),
    .b       (HALF_PI_Q16),
    .done    (mult_done),
    .product (product)
  );

`ifdef ALU_COS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  logic [WAIT_W-1:0] wait_cnt;

  // compare two short so the registered strobe lands TIMEOUT_CYCLES after cos_do_calc
  assign timeout_hit = (state == ST_WAIT) && !cos_calc_done &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      timeout_err <= timeout_hit;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (accept) state_next = ST_SCALE;
      ST_SCALE: if (mult_done) state_next = ST_REQ;
      ST_REQ:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (cos_calc_done)    state_next = ST_SIGN;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_SIGN:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // p0: quadrant sign captured alongside the accepted phase
  always_ff @(posedge clk) begin
    if (accept) neg_p0 <= neg_fold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cos_do_calc   <= 1'b0;
      cos_out_valid <= 1'b0;
      cos_x         <= '0;
      cos_out       <= '0;
    end else begin
      state         <= state_next;
      cos_do_calc   <= (state_next == ST_REQ);
      cos_out_valid <= (state_next == ST_SIGN);
      if (state == ST_SCALE && mult_done)
        cos_x <= $signed(product[FRAC_W +: DATA_W]);
      if (state == ST_WAIT && cos_calc_done)
        cos_out <= neg_p0 ? negate_wrap(cos_res) : cos_res;
      else if (timeout_hit)
        cos_out <= '0;
    end
  end

endmodule
